// File: rtl/puf_request_arbiter.sv
// Round-robin arbiter sharing one 16-bit RO PUF between NUM_REQ requesters.
// Optional WAIT timeout abort is enabled by defining the macro PUF_TIMEOUT_EN.
module puf_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [5*NUM_REQ-1:0] req_challenge,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 puf_enable,
  output logic [4:0]           puf_challenge,
  input  logic [15:0]          puf_response,
  input  logic                 puf_response_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [4:0]       pick_chal;
  logic             wait_done;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] o;
    o      = '0;
    o[idx] = 1'b1;
    return o;
  endfunction

  // Search starts at ptr so the requester after the last one served wins ties.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && req[wrap_idx(ptr, k)]) begin
        pick_vld = 1'b1;
        pick     = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    pick_chal = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick) pick_chal = req_challenge[5*i +: 5];
    end
  end

`ifdef PUF_TIMEOUT_EN
  logic [19:0] tmo_cnt;
  logic        err_q;

  // A valid arriving in the last allowed cycle still counts as a real response.
  always_comb begin
    wait_done = 1'b0;
    if (state == S_WAIT) begin
      wait_done = puf_response_valid || (tmo_cnt == 20'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && pick_vld) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT && !puf_response_valid) begin
        tmo_cnt <= tmo_cnt + 20'd1;
      end
      if (wait_done) err_q <= !puf_response_valid;
    end
  end

  assign rsp_err = err_q;
`else
  always_comb begin
    wait_done = 1'b0;
    if (state == S_WAIT) wait_done = puf_response_valid;
  end

  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= '0;
      winner        <= '0;
      gnt           <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      puf_enable    <= 1'b0;
      puf_challenge <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            winner        <= pick;
            gnt           <= onehot(pick);
            puf_enable    <= 1'b1;
            puf_challenge <= pick_chal;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            rsp_data   <= puf_response_valid ? puf_response : 16'h0000;
            gnt        <= '0;
            puf_enable <= 1'b0;
            rsp_valid  <= onehot(winner);
            ptr        <= wrap_idx(winner, 1);
            state      <= S_DELIVER;
          end
        end
        S_DELIVER: begin
          rsp_valid <= '0;
          state     <= S_RELEASE;
        end
        // Hold off new grants until the PUF drops valid, so a stale valid is never captured.
        S_RELEASE: begin
          if (!puf_response_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_puf_request_arbiter.sv
// Bench for puf_request_arbiter: per-cycle reference model plus directed scenarios.
// Define PUF_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYCLES=100).
module tb_puf_request_arbiter;

  localparam int N = 4;
`ifdef PUF_TIMEOUT_EN
  localparam int TB_TO = 100;
`else
  localparam int TB_TO = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [5*N-1:0] req_challenge = {5'd9, 5'd7, 5'd5, 5'd3};
  logic [N-1:0]  gnt, rsp_valid;
  logic [15:0]   rsp_data;
  logic          rsp_err, busy, puf_enable;
  logic [4:0]    puf_challenge;
  logic [15:0]   puf_response = '0;
  logic          puf_response_valid = 1'b0;

  puf_request_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES((TB_TO > 0) ? TB_TO : 65536)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_challenge(req_challenge),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .puf_enable(puf_enable), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .puf_response_valid(puf_response_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // PUF responder
  bit          auto_en    = 1'b0;
  int          resp_delay = 10;
  int          resp_hold  = 0;
  logic [15:0] next_resp  = 16'h0000;
  int          wait_cnt   = 0;
  int          hold_left  = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (puf_response_valid) begin
        if (hold_left > 0) hold_left--;
        else begin
          puf_response_valid = 1'b0;
          wait_cnt = 0;
        end
      end else if (puf_enable && auto_en) begin
        wait_cnt++;
        if (wait_cnt >= resp_delay) begin
          puf_response_valid = 1'b1;
          puf_response       = next_resp;
          hold_left          = resp_hold;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Reference model: who owns the PUF, who is being answered, whether we wait for valid to drop.
  int          m_owner = -1;
  int          m_dlv   = -1;
  bit          m_hold  = 1'b0;
  int          m_ptr   = 0;
  int          m_wcnt  = 0;
  logic [15:0] m_data  = '0;
  logic        m_err   = 1'b0;
  logic [4:0]  m_chal  = '0;

  logic          p_rst = 1'b1;
  logic [N-1:0]  p_req = '0;
  logic [5*N-1:0] p_ch = '0;
  logic          p_v   = 1'b0;
  logic [15:0]   p_resp = '0;

  int glog[$];
  logic [N-1:0] prev_gnt = '0;

  function automatic int log_at(input int i);
    if (i < glog.size()) return glog[i];
    return -1;
  endfunction

  task automatic m_deliver(input logic [15:0] d, input logic e);
    m_data  = d;
    m_err   = e;
    m_dlv   = m_owner;
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg, ev;
    if (p_rst) begin
      m_owner = -1; m_dlv = -1; m_hold = 1'b0; m_ptr = 0; m_wcnt = 0;
      m_data = '0; m_err = 1'b0; m_chal = '0;
    end else if (m_dlv >= 0) begin
      m_dlv  = -1;
      m_hold = 1'b1;
    end else if (m_hold) begin
      if (!p_v) m_hold = 1'b0;
    end else if (m_owner >= 0) begin
      if (p_v) m_deliver(p_resp, 1'b0);
      else if (TB_TO > 0) begin
        m_wcnt++;
        if (m_wcnt == TB_TO) m_deliver(16'h0000, 1'b1);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int w;
        w = (m_ptr + k) % N;
        if (m_owner < 0 && p_req[w]) begin
          m_owner = w;
          m_chal  = p_ch[5*w +: 5];
          m_wcnt  = 0;
        end
      end
    end

    eg = '0; ev = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_dlv >= 0)   ev[m_dlv]   = 1'b1;
    chk("gnt", gnt, eg);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_err", rsp_err, m_err);
    chk("puf_enable", puf_enable, m_owner >= 0);
    chk("puf_challenge", puf_challenge, m_chal);
    chk("busy", busy, (m_owner >= 0) || (m_dlv >= 0) || m_hold);

    if (prev_gnt == '0 && gnt != '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
    end
    prev_gnt = gnt;

    p_rst = rst; p_req = req; p_ch = req_challenge;
    p_v = puf_response_valid; p_resp = puf_response;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c = 0;
    while (glog.size() < n && c < budget) begin tick(1); c++; end
    chk(nm, glog.size() >= n, 1'b1);
  endtask

  task automatic wait_rsp(input int budget, input string nm);
    int c = 0;
    while (rsp_valid == '0 && c < budget) begin tick(1); c++; end
    chk(nm, rsp_valid != '0, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int c = 0;
    while ((busy || rsp_valid != '0) && c < budget) begin tick(1); c++; end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick(3);
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_enable", puf_enable, 1'b0);
    chk("reset_data", rsp_data, 16'h0000);
    rst = 1'b0;
    tick(1);

    // All four requesting: strict rotation starting from req0
    auto_en = 1'b1; resp_delay = 10; resp_hold = 0; next_resp = 16'h1234;
    req = 4'b1111;
    wait_log(5, 200, "rr_grants_timeout");
    req = 4'b0000;
    wait_idle(50, "rr_idle");
    chk("rr_order0", log_at(0), 0);
    chk("rr_order1", log_at(1), 1);
    chk("rr_order2", log_at(2), 2);
    chk("rr_order3", log_at(3), 3);
    chk("rr_order4", log_at(4), 0);

    // Single request: one-edge latency, challenge capture, response delivery
    resp_delay = 3; next_resp = 16'hA5C3;
    req = 4'b0001;
    tick(1);
    chk("lat_enable", puf_enable, 1'b1);
    chk("lat_challenge", puf_challenge, 5'd3);
    chk("lat_gnt", gnt, 4'b0001);
    req = 4'b0000;
    wait_rsp(20, "single_rsp_timeout");
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 16'hA5C3);
    chk("single_rsp_err", rsp_err, 1'b0);
    tick(1);
    chk("single_rsp_pulse", rsp_valid, 4'b0000);
    wait_idle(20, "single_idle");

    // After req0 was served, req2 beats req0
    next_resp = 16'h0F0F;
    req = 4'b0101;
    wait_log(8, 100, "ptr_grants_timeout");
    req = 4'b0000;
    wait_idle(50, "ptr_idle");
    chk("ptr_first", log_at(6), 2);
    chk("ptr_second", log_at(7), 0);

    // Stale valid held after delivery must not start or feed the next service
    resp_hold = 5; next_resp = 16'h1111;
    req = 4'b0001;
    wait_log(9, 20, "stale_grant0_timeout");
    req = 4'b0010;
    wait_rsp(20, "stale_rsp0_timeout");
    chk("stale_rsp0_valid", rsp_valid, 4'b0001);
    chk("stale_rsp0_data", rsp_data, 16'h1111);
    resp_hold = 0; next_resp = 16'h2222;
    for (int i = 0; i < 20 && puf_response_valid; i++) begin
      chk("stale_no_gnt", gnt, 4'b0000);
      tick(1);
    end
    chk("stale_valid_fell", puf_response_valid, 1'b0);
    wait_log(10, 20, "stale_grant1_timeout");
    chk("stale_grant1", log_at(9), 1);
    req = 4'b0000;
    wait_rsp(20, "stale_rsp1_timeout");
    chk("stale_rsp1_valid", rsp_valid, 4'b0010);
    chk("stale_rsp1_data", rsp_data, 16'h2222);
    wait_idle(20, "stale_idle");

    // Reset in WAIT while serving req2 aborts; priority returns to req0 side
    resp_delay = 50; next_resp = 16'h3333;
    req = 4'b0110;
    wait_log(11, 20, "rst_grant_timeout");
    chk("rst_serving", log_at(10), 2);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_enable", puf_enable, 1'b0);
    chk("rst_challenge", puf_challenge, 5'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(1);
    chk("rst_regrant", gnt, 4'b0010);
    req = 4'b0000;
    wait_rsp(80, "rst_rsp_timeout");
    chk("rst_rsp_data", rsp_data, 16'h3333);
    wait_idle(20, "rst_idle");

    // PUF never answers
    auto_en = 1'b0;
    req = 4'b0001;
    tick(1);
    chk("tmo_gnt", gnt, 4'b0001);
    req = 4'b0000;
`ifdef PUF_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (rsp_valid == '0 && n < 300) begin tick(1); n++; end
      chk("tmo_cycles", n, 100);
      chk("tmo_rsp_valid", rsp_valid, 4'b0001);
      chk("tmo_err", rsp_err, 1'b1);
      chk("tmo_data", rsp_data, 16'h0000);
      wait_idle(20, "tmo_idle");
    end
`else
    tick(1000);
    chk("notmo_enable", puf_enable, 1'b1);
    chk("notmo_busy", busy, 1'b1);
    chk("notmo_gnt", gnt, 4'b0001);
    chk("notmo_err", rsp_err, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("notmo_cleared", puf_enable, 1'b0);
`endif

    tick(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
